// File: rtl/monopix_ro_sequencer_pkg.sv
// rtl/monopix_ro_sequencer_pkg.sv - shared types and helpers for the MONOPIX readout sequencer
// Purpose: FSM state encoding, hit-word field layout, counter widths and the
//   gray-to-binary decoder used on the te/le timestamp fields.
// Ports: none (package).
package monopix_ro_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TOKEN_WAIT,
    READ,
    DATA
  } t_ro_state;

  // Hit word as shifted out by the chip, MSB first.
  typedef struct packed {
    logic [5:0] col;
    logic [5:0] te;
    logic [5:0] le;
    logic [8:0] row;
  } t_data;

  localparam int CNT_W      = 8;
  localparam int WORD_CNT_W = 16;

  // Timestamps leave the chip gray coded.
  function automatic logic [5:0] gray2bin6(input logic [5:0] g);
    logic [5:0] b;
    b[5] = g[5];
    for (int i = 4; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/monopix_ro_sequencer_if.sv
// rtl/monopix_ro_sequencer_if.sv - chip pad and FIFO read bundle for one readout channel
// Purpose: groups the chip-side pads (token, data_in, read, freeze) with the
//   FIFO read side and status (fifo_rd, fifo_dout, fifo_empty, fifo_full,
//   enable, stall, word_cnt).
// Modports: slave = the sequencer, master = the chip/consumer side.
interface monopix_ro_if #(
  parameter int WORD_W = 27
);
  import monopix_ro_pkg::*;

  logic                  enable;
  logic                  token;
  logic                  data_in;
  logic                  read;
  logic                  freeze;
  logic                  stall;
  logic                  fifo_rd;
  logic [WORD_W-1:0]     fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [WORD_CNT_W-1:0] word_cnt;

  modport slave (
    input  enable, token, data_in, fifo_rd,
    output read, freeze, stall, fifo_dout, fifo_empty, fifo_full, word_cnt
  );

  modport master (
    output enable, token, data_in, fifo_rd,
    input  read, freeze, stall, fifo_dout, fifo_empty, fifo_full, word_cnt
  );

endinterface

// File: rtl/monopix_ro_sequencer_fifo.sv
// rtl/monopix_ro_sequencer_fifo.sv - single-clock first-word-fall-through FIFO
// Purpose: buffers deserialised hit words; head word is visible on dout while
//   not empty (dout reads 0 when empty).
// Ports: clk, reset (sync, active-high), push/push_data, pop, dout, count,
//   empty, full. Pop on empty is ignored; push on full is only accepted
//   together with a pop.
module ro_sync_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/monopix_ro_sequencer.sv
// rtl/monopix_ro_sequencer.sv - token/freeze/read readout sequencer for one MONOPIX channel
// Purpose: on TOKEN runs FREEZE/READ, deserialises the chip OUT line into
//   WORD_W-bit hit words and buffers them in an on-block FIFO.
// Ports: clk_bx, reset (sync, active-high), bus (monopix_ro_if.slave):
//   enable/token/data_in/fifo_rd in; read/freeze/stall/fifo_dout/fifo_empty/
//   fifo_full/word_cnt out.
module monopix_ro_sequencer #(
  parameter int WORD_W     = 27,
  parameter int TOKEN_DLY  = 2,
  parameter int READ_LEN   = 2,
  parameter int SER_LAT    = 3,
  parameter int DATA_LEN   = 30,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk_bx,
  input  logic         reset,
  monopix_ro_if.slave  bus
);
  import monopix_ro_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if (SER_LAT + WORD_W > DATA_LEN || TOKEN_DLY < 1 || READ_LEN < 1 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("monopix_ro_sequencer: illegal parameter set");
  end

  t_ro_state         state;
  t_ro_state         next_state;
  logic [CNT_W-1:0]  cnt;
  logic              leave;
  logic [WORD_W-2:0] ser;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       occupancy;
  logic              space;
  logic              go;
  logic              push;
  logic [WORD_W-1:0] push_word;

  // A running transaction already owns a FIFO slot, so a start is refused
  // unless both the stored words and the in-flight one fit.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, (state != IDLE)};
  assign space     = occupancy < (CW+1)'(FIFO_DEPTH);
  assign go        = bus.token & bus.enable & space;

  assign push      = (state == DATA) && (cnt == CNT_W'(SER_LAT + WORD_W - 1));
  assign push_word = {ser, bus.data_in};

  always_comb begin
    next_state = state;
    leave      = 1'b0;
    case (state)
      IDLE: begin
        if (go) next_state = TOKEN_WAIT;
      end
      TOKEN_WAIT: begin
        if (cnt == CNT_W'(TOKEN_DLY - 1)) begin
          leave      = 1'b1;
          next_state = READ;
        end
      end
      READ: begin
        if (cnt == CNT_W'(READ_LEN - 1)) begin
          leave      = 1'b1;
          next_state = DATA;
        end
      end
      DATA: begin
        // Token held and room left: chain straight into the next readout.
        if (cnt == CNT_W'(DATA_LEN - 1)) begin
          leave      = 1'b1;
          next_state = go ? TOKEN_WAIT : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_bx) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bus.read   <= 1'b0;
      bus.freeze <= 1'b0;
      bus.stall  <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= (state == IDLE || leave) ? '0 : cnt + 1'b1;
      bus.read   <= (next_state == READ);
      bus.freeze <= (next_state == TOKEN_WAIT) || (next_state == READ);
      bus.stall  <= (state == IDLE) && bus.token && bus.enable && !space;
    end
  end

  always_ff @(posedge clk_bx) begin
    if (reset) ser <= '0;
    else       ser <= {ser[WORD_W-3:0], bus.data_in};
  end

  always_ff @(posedge clk_bx) begin
    if (reset)                      bus.word_cnt <= '0;
    else if (push && ~&bus.word_cnt) bus.word_cnt <= bus.word_cnt + 1'b1;
  end

  ro_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_bx),
    .reset     (reset),
    .push      (push),
    .push_data (push_word),
    .pop       (bus.fifo_rd),
    .dout      (bus.fifo_dout),
    .count     (fifo_count),
    .empty     (bus.fifo_empty),
    .full      (bus.fifo_full)
  );

endmodule
